// File: rtl/xadac_slv_mac_if.sv
// rtl/xadac_slv_mac_if.sv - XADAC payload types and the decode/execute interface
package xadac_pkg;
    localparam int IdW = 4;

    typedef logic [IdW-1:0] id_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] instr;
    } dec_req_t;

    typedef struct packed {
        id_t  id;
        logic accept;
    } dec_rsp_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exe_req_t;

    typedef struct packed {
        id_t         id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exe_rsp_t;
endpackage

interface xadac_if;
    import xadac_pkg::*;

    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_req_t dec_req;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    dec_rsp_t dec_rsp;
    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_req_t exe_req;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;
    exe_rsp_t exe_rsp;

    modport mst (
        output dec_req_valid, dec_req, dec_rsp_ready,
        output exe_req_valid, exe_req, exe_rsp_ready,
        input  dec_req_ready, dec_rsp_valid, dec_rsp,
        input  exe_req_ready, exe_rsp_valid, exe_rsp
    );

    modport slv (
        input  dec_req_valid, dec_req, dec_rsp_ready,
        input  exe_req_valid, exe_req, exe_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp,
        output exe_req_ready, exe_rsp_valid, exe_rsp
    );
endinterface

// File: rtl/xadac_slv_mac.sv
// rtl/xadac_slv_mac.sv - XADAC MUL/MAC responder; XADAC_SLV_MAC_ACC_EN enables the accumulator
module xadac_slv_mac #(
    parameter int         Latency = 2,
    parameter int         Depth   = 4,
    parameter logic [6:0] Opcode  = 7'b0001011
) (
    input logic  clk,
    input logic  rst,
    xadac_if.slv slv
);
    import xadac_pkg::*;

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(Depth);
    localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);

    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_MAC = 3'b001;
    localparam logic [2:0] F3_CLR = 3'b010;

    logic unused_instr;
    assign unused_instr = ^{slv.dec_req.instr, slv.exe_req.instr};

    // ---------------- decode ----------------
    logic [2:0] dec_f3;
    logic       dec_accept;
    logic       dec_fire;
    logic       dec_valid_q;
    dec_rsp_t   dec_rsp_q;

    assign dec_f3 = slv.dec_req.instr[14:12];

    always_comb begin
        dec_accept = 1'b0;
        if (slv.dec_req.instr[6:0] == Opcode) begin
`ifdef XADAC_SLV_MAC_ACC_EN
            dec_accept = (dec_f3 == F3_MUL) || (dec_f3 == F3_MAC) || (dec_f3 == F3_CLR);
`else
            dec_accept = (dec_f3 == F3_MUL);
`endif
        end
    end

    assign slv.dec_req_ready = (!dec_valid_q || slv.dec_rsp_ready) && !rst;
    assign dec_fire          = slv.dec_req_valid && slv.dec_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid_q <= 1'b0;
            dec_rsp_q   <= '0;
        end else if (dec_fire) begin
            dec_valid_q      <= 1'b1;
            dec_rsp_q.id     <= slv.dec_req.id;
            dec_rsp_q.accept <= dec_accept;
        end else if (slv.dec_rsp_ready) begin
            dec_valid_q <= 1'b0;
        end
    end

    assign slv.dec_rsp_valid = dec_valid_q;
    assign slv.dec_rsp       = dec_rsp_q;

    // ---------------- execute issue ----------------
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] fifo_cnt;
    logic          exe_fire;
    logic          rsp_fire;
    logic [31:0]   product;
    logic [31:0]   issue_data;
    exe_rsp_t      issue_rsp;

    // Credits cover both pipeline and FIFO, so neither can ever overflow.
    assign slv.exe_req_ready = (out_cnt < DEPTH_C) && !rst;
    assign exe_fire          = slv.exe_req_valid && slv.exe_req_ready;
    assign rsp_fire          = slv.exe_rsp_valid && slv.exe_rsp_ready;
    assign product           = slv.exe_req.rs1 * slv.exe_req.rs2;

`ifdef XADAC_SLV_MAC_ACC_EN
    logic [2:0]  exe_f3;
    logic [31:0] acc_q;
    logic [31:0] acc_nxt;

    assign exe_f3 = slv.exe_req.instr[14:12];

    // Accumulator moves at issue so consecutive MACs chain without waiting on the pipeline.
    always_comb begin
        acc_nxt    = acc_q;
        issue_data = product;
        case (exe_f3)
            F3_MAC: begin
                acc_nxt    = acc_q + product;
                issue_data = acc_q + product;
            end
            F3_CLR: begin
                acc_nxt    = '0;
                issue_data = acc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (exe_fire) begin
            acc_q <= acc_nxt;
        end
    end
`else
    assign issue_data = product;
`endif

    assign issue_rsp = '{id: slv.exe_req.id, rd: slv.exe_req.instr[11:7], data: issue_data, we: 1'b1};

    // ---------------- fixed-latency pipeline ----------------
    exe_rsp_t fifo_in;
    logic     fifo_we;

    // The FIFO write itself is the last stage, hence Latency-1 shift registers.
    if (Latency == 1) begin : g_nopipe
        assign fifo_in = issue_rsp;
        assign fifo_we = exe_fire;
    end else begin : g_pipe
        logic [Latency-2:0] pipe_v;
        exe_rsp_t           pipe_d [Latency-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_v <= '0;
                for (int k = 0; k < Latency - 1; k++) begin
                    pipe_d[k] <= '0;
                end
            end else begin
                pipe_v[0] <= exe_fire;
                pipe_d[0] <= issue_rsp;
                for (int k = 1; k < Latency - 1; k++) begin
                    pipe_v[k] <= pipe_v[k-1];
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end

        assign fifo_in = pipe_d[Latency-2];
        assign fifo_we = pipe_v[Latency-2];
    end

    // ---------------- output FIFO ----------------
    exe_rsp_t      fifo_mem [Depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            for (int k = 0; k < Depth; k++) begin
                fifo_mem[k] <= '0;
            end
        end else begin
            if (fifo_we) begin
                fifo_mem[wr_ptr] <= fifo_in;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (rsp_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({fifo_we, rsp_fire})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
            case ({exe_fire, rsp_fire})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    assign slv.exe_rsp_valid = (fifo_cnt != '0);
    assign slv.exe_rsp       = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_xadac_slv_mac.sv
// tb/tb_xadac_slv_mac.sv - randomized self-checking bench for xadac_slv_mac
module tb_xadac_slv_mac;
    localparam int L = 2;
    localparam int D = 4;
`ifdef XADAC_SLV_MAC_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xadac_if bus ();

    xadac_slv_mac #(.Latency(L), .Depth(D), .Opcode(7'b0001011)) dut (
        .clk (clk),
        .rst (rst),
        .slv (bus)
    );

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        int          t;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] m_acc = 0;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, 7'h0B};
    endfunction

    function automatic bit model_accept(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (ins[6:0] != 7'h0B) return 1'b0;
        if (f3 == 3'd0) return 1'b1;
        return ACC && (f3 == 3'd1 || f3 == 3'd2);
    endfunction

    function automatic logic [31:0] model_exec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        logic [31:0] old;
        p = a * b;
        if (ACC && f3 == 3'd1) begin
            m_acc = m_acc + p;
            return m_acc;
        end
        if (ACC && f3 == 3'd2) begin
            old   = m_acc;
            m_acc = 0;
            return old;
        end
        return p;
    endfunction

    task automatic drive_exe(input logic v, input logic [3:0] id, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        bus.exe_req_valid     = v;
        bus.exe_req.id        = id;
        bus.exe_req.instr     = mk_instr(f3, rd);
        bus.exe_req.rs1       = a;
        bus.exe_req.rs2       = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.dec_req_valid = 0; bus.dec_req = '0; bus.dec_rsp_ready = 1;
        bus.exe_req_valid = 0; bus.exe_req = '0; bus.exe_rsp_ready = 1;
        tick; tick;
        total++; if (bus.dec_req_ready !== 1'b0) begin bad++; $display("FAIL rst_dec_ready got=%b exp=0", bus.dec_req_ready); end
        total++; if (bus.exe_req_ready !== 1'b0) begin bad++; $display("FAIL rst_exe_ready got=%b exp=0", bus.exe_req_ready); end
        total++; if (bus.dec_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%b exp=0", bus.dec_rsp_valid); end
        total++; if (bus.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_exe_valid got=%b exp=0", bus.exe_rsp_valid); end
        tick;
        rst = 1'b0;
        m_acc = 0;
        #1;
        total++; if (bus.dec_req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_dec_ready got=%b exp=1", bus.dec_req_ready); end
        total++; if (bus.exe_req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_exe_ready got=%b exp=1", bus.exe_req_ready); end
        total++; if (bus.dec_rsp !== '0) begin bad++; $display("FAIL post_rst_dec_payload got=%h exp=0", bus.dec_rsp); end
        total++; if (bus.exe_rsp !== '0) begin bad++; $display("FAIL post_rst_exe_payload got=%h exp=0", bus.exe_rsp); end
        tick;
    endtask

    task automatic test_decode;
        logic [31:0] ins_tab [4];
        logic [3:0]  exp_id;
        logic        exp_acc;
        logic        exp_v;
        logic        rr;
        logic        rv;
        logic [31:0] ins;
        logic [3:0]  id;
        ins_tab[0] = 32'h0020_A00B;
        ins_tab[1] = 32'h0000_0033;
        ins_tab[2] = 32'h0000_100B;
        ins_tab[3] = 32'h0000_028B;
        bus.dec_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.dec_req_valid = 1'b1;
            bus.dec_req.id    = 4'(3 + i);
            bus.dec_req.instr = ins_tab[i];
            tick;
            total++; if (bus.dec_rsp_valid !== 1'b1) begin bad++; $display("FAIL dec_dir_valid[%0d] got=%b exp=1", i, bus.dec_rsp_valid); end
            total++; if (bus.dec_rsp.id !== 4'(3 + i)) begin bad++; $display("FAIL dec_dir_id[%0d] got=%0d exp=%0d", i, bus.dec_rsp.id, 3 + i); end
            total++; if (bus.dec_rsp.accept !== model_accept(ins_tab[i])) begin bad++; $display("FAIL dec_dir_accept[%0d] got=%b exp=%b", i, bus.dec_rsp.accept, model_accept(ins_tab[i])); end
        end
        bus.dec_req_valid = 1'b0;
        tick;
        total++; if (bus.dec_rsp_valid !== 1'b0) begin bad++; $display("FAIL dec_idle_valid got=%b exp=0", bus.dec_rsp_valid); end

        exp_v = 0; exp_id = 0; exp_acc = 0;
        for (int n = 0; n < 200; n++) begin
            total++; if (bus.dec_rsp_valid !== exp_v) begin bad++; $display("FAIL dec_rnd_valid c%0d got=%b exp=%b", cyc, bus.dec_rsp_valid, exp_v); end
            if (exp_v) begin
                total++; if (bus.dec_rsp.id !== exp_id || bus.dec_rsp.accept !== exp_acc) begin
                    bad++; $display("FAIL dec_rnd_payload c%0d got=%0d/%b exp=%0d/%b", cyc, bus.dec_rsp.id, bus.dec_rsp.accept, exp_id, exp_acc);
                end
            end
            rr  = 1'($urandom % 2);
            rv  = 1'($urandom % 2);
            ins = $urandom;
            if ($urandom % 4 != 0) ins[6:0] = 7'h0B;
            id  = 4'($urandom);
            bus.dec_rsp_ready = rr;
            bus.dec_req_valid = rv;
            bus.dec_req.id    = id;
            bus.dec_req.instr = ins;
            #1;
            total++; if (bus.dec_req_ready !== (!exp_v || rr)) begin bad++; $display("FAIL dec_rnd_ready c%0d got=%b exp=%b", cyc, bus.dec_req_ready, !exp_v || rr); end
            if (exp_v && rr) exp_v = 0;
            if (rv && bus.dec_req_ready) begin
                exp_v   = 1;
                exp_id  = id;
                exp_acc = model_accept(ins);
            end
            tick;
        end
        bus.dec_req_valid = 1'b0;
        bus.dec_rsp_ready = 1'b1;
        tick; tick;
    endtask

    task automatic test_mul;
        bus.exe_rsp_ready = 1'b1;
        drive_exe(1'b1, 4'd7, 3'd0, 5'd5, 32'hFFFF_FFFF, 32'd2);
        #1;
        total++; if (bus.exe_req_ready !== 1'b1) begin bad++; $display("FAIL mul_ready got=%b exp=1", bus.exe_req_ready); end
        tick;
        bus.exe_req_valid = 1'b0;
        total++; if (bus.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL mul_early got=%b exp=0", bus.exe_rsp_valid); end
        tick;
        total++; if (bus.exe_rsp_valid !== 1'b1) begin bad++; $display("FAIL mul_valid got=%b exp=1", bus.exe_rsp_valid); end
        total++; if (bus.exe_rsp.data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_data got=%h exp=fffffffe", bus.exe_rsp.data); end
        total++; if (bus.exe_rsp.rd !== 5'd5 || bus.exe_rsp.we !== 1'b1 || bus.exe_rsp.id !== 4'd7) begin
            bad++; $display("FAIL mul_fields got=rd%0d we%b id%0d exp=rd5 we1 id7", bus.exe_rsp.rd, bus.exe_rsp.we, bus.exe_rsp.id);
        end
        tick;
        total++; if (bus.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL mul_after got=%b exp=0", bus.exe_rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s  [5];
        logic [31:0] as   [5];
        logic [31:0] bs   [5];
        logic [31:0] want [5];
        logic [31:0] got  [5];
        logic [4:0]  grd  [5];
        int          ngot;
        f3s[0] = 3'd1; as[0] = 3; bs[0] = 4;
        f3s[1] = 3'd1; as[1] = 5; bs[1] = 6;
        f3s[2] = 3'd2; as[2] = 2; bs[2] = 3;
        f3s[3] = 3'd0; as[3] = 7; bs[3] = 7;
        f3s[4] = 3'd2; as[4] = 4; bs[4] = 5;
        if (ACC) begin
            want[0] = 12; want[1] = 42; want[2] = 42; want[3] = 49; want[4] = 0;
        end else begin
            want[0] = 12; want[1] = 30; want[2] = 6; want[3] = 49; want[4] = 20;
        end
        bus.exe_rsp_ready = 1'b1;
        ngot = 0;
        for (int n = 0; n < 20 && ngot < 5; n++) begin
            if (bus.exe_rsp_valid) begin
                got[ngot] = bus.exe_rsp.data;
                grd[ngot] = bus.exe_rsp.rd;
                ngot++;
            end
            if (n < 5) begin
                drive_exe(1'b1, 4'(n), f3s[n], 5'(n + 1), as[n], bs[n]);
                #1;
                total++; if (bus.exe_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_stall[%0d] got=%b exp=1", n, bus.exe_req_ready); end
            end else begin
                bus.exe_req_valid = 1'b0;
            end
            tick;
        end
        bus.exe_req_valid = 1'b0;
        total++; if (ngot != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", ngot); end
        for (int i = 0; i < ngot; i++) begin
            total++; if (got[i] !== want[i] || grd[i] !== 5'(i + 1)) begin
                bad++; $display("FAIL b2b_data[%0d] got=%0d rd%0d exp=%0d rd%0d", i, got[i], grd[i], want[i], i + 1);
            end
        end
        m_acc = 0;
        tick;
    endtask

    task automatic test_backpressure;
        int         accepted;
        int         ngot;
        logic [3:0] ids [3];
        bus.exe_rsp_ready = 1'b0;
        accepted = 0;
        for (int n = 0; n < 8; n++) begin
            drive_exe(1'b1, 4'(8 + accepted), 3'd0, 5'(n), 32'(n), 32'd3);
            #1;
            if (bus.exe_req_ready) accepted++;
            tick;
        end
        bus.exe_req_valid = 1'b0;
        total++; if (accepted != D) begin bad++; $display("FAIL bp_accepted got=%0d exp=%0d", accepted, D); end
        total++; if (bus.exe_req_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", bus.exe_req_ready); end
        total++; if (bus.exe_rsp_valid !== 1'b1 || bus.exe_rsp.id !== 4'd8) begin
            bad++; $display("FAIL bp_head got=v%b id%0d exp=v1 id8", bus.exe_rsp_valid, bus.exe_rsp.id);
        end
        bus.exe_rsp_ready = 1'b1;
        tick;
        bus.exe_rsp_ready = 1'b0;
        total++; if (bus.exe_req_ready !== 1'b1) begin bad++; $display("FAIL bp_credit_back got=%b exp=1", bus.exe_req_ready); end
        bus.exe_rsp_ready = 1'b1;
        ngot = 0;
        for (int n = 0; n < 12 && ngot < 3; n++) begin
            if (bus.exe_rsp_valid) begin
                ids[ngot] = bus.exe_rsp.id;
                ngot++;
            end
            tick;
        end
        total++; if (ngot != 3) begin bad++; $display("FAIL bp_drain_count got=%0d exp=3", ngot); end
        for (int i = 0; i < ngot; i++) begin
            total++; if (ids[i] !== 4'(9 + i)) begin bad++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, ids[i], 9 + i); end
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [31:0] want;
        int          seen;
        bus.exe_rsp_ready = 1'b0;
        bus.dec_rsp_ready = 1'b0;
        bus.dec_req_valid = 1'b1;
        bus.dec_req.id    = 4'd2;
        bus.dec_req.instr = 32'h0000_000B;
        drive_exe(1'b1, 4'd1, 3'd1, 5'd1, 32'd5, 32'd5);
        tick;
        bus.dec_req_valid = 1'b0;
        drive_exe(1'b1, 4'd2, 3'd0, 5'd2, 32'd6, 32'd6);
        tick;
        drive_exe(1'b1, 4'd3, 3'd0, 5'd3, 32'd8, 32'd8);
        tick;
        bus.exe_req_valid = 1'b0;
        rst = 1'b1;
        tick;
        total++; if (bus.exe_req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", bus.exe_req_ready); end
        rst = 1'b0;
        m_acc = 0;
        bus.exe_rsp_ready = 1'b1;
        bus.dec_rsp_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (bus.exe_rsp_valid !== 1'b0 || bus.dec_rsp_valid !== 1'b0) seen++;
            total++; if (bus.exe_req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready[%0d] got=%b exp=1", n, bus.exe_req_ready); end
            tick;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_stale_rsp got=%0d exp=0", seen); end
        want = model_exec(3'd1, 32'd2, 32'd3);
        drive_exe(1'b1, 4'd5, 3'd1, 5'd9, 32'd2, 32'd3);
        tick;
        bus.exe_req_valid = 1'b0;
        tick;
        total++; if (bus.exe_rsp_valid !== 1'b1 || bus.exe_rsp.data !== want || bus.exe_rsp.id !== 4'd5) begin
            bad++; $display("FAIL mid_acc_cleared got=v%b d%0d id%0d exp=v1 d%0d id5", bus.exe_rsp_valid, bus.exe_rsp.data, bus.exe_rsp.id, want);
        end
        tick; tick;
    endtask

    task automatic test_random_exe;
        exp_t        q [$];
        exp_t        e;
        logic        exp_valid;
        logic        rsp_rdy;
        logic        req_v;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  id;
        logic [4:0]  rd;
        for (int n = 0; n < 430; n++) begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].t + L);
            total++; if (bus.exe_rsp_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid c%0d got=%b exp=%b", cyc, bus.exe_rsp_valid, exp_valid); end
            if (exp_valid) begin
                total++; if (bus.exe_rsp.id !== q[0].id || bus.exe_rsp.rd !== q[0].rd || bus.exe_rsp.data !== q[0].data || bus.exe_rsp.we !== 1'b1) begin
                    bad++; $display("FAIL rnd_payload c%0d got=id%0d rd%0d d%h exp=id%0d rd%0d d%h", cyc, bus.exe_rsp.id, bus.exe_rsp.rd, bus.exe_rsp.data, q[0].id, q[0].rd, q[0].data);
                end
            end
            total++; if (bus.exe_req_ready !== (q.size() < D)) begin bad++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, bus.exe_req_ready, q.size() < D); end
            if (n < 400) begin
                rsp_rdy = ($urandom % 4) != 0;
                req_v   = ($urandom % 3) != 0;
            end else begin
                rsp_rdy = 1'b1;
                req_v   = 1'b0;
            end
            f3 = 3'($urandom % 4);
            a  = ($urandom % 2) ? $urandom : 32'($urandom % 16);
            b  = ($urandom % 2) ? $urandom : 32'($urandom % 16);
            id = 4'($urandom);
            rd = 5'($urandom);
            bus.exe_rsp_ready = rsp_rdy;
            drive_exe(req_v, id, f3, rd, a, b);
            #1;
            if (bus.exe_rsp_valid && rsp_rdy) void'(q.pop_front());
            if (req_v && bus.exe_req_ready) begin
                e.id   = id;
                e.rd   = rd;
                e.data = model_exec(f3, a, b);
                e.t    = cyc;
                q.push_back(e);
            end
            tick;
        end
        bus.exe_req_valid = 1'b0;
        total++; if (q.size() != 0 || bus.exe_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rnd_drain got=q%0d v%b exp=q0 v0", q.size(), bus.exe_rsp_valid);
        end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_mul;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_random_exe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/xadac_slv_mac.md
# xadac_slv_mac

Responder-side XADAC accelerator: the slave end of the `xadac_if` decode/execute protocol, sitting behind the core's XADAC master port, optionally through skid stages. It decodes custom-0 instructions and accepts or rejects them, then executes accepted multiply / multiply-accumulate operations in order. Results return through a fixed-latency pipeline with credit-limited buffering. It is the first real compute slave on the interface and serves as the reference responder for interface verification.

## Interface
- `Latency`, 2: execute pipeline depth in cycles, ≥1.
- `Depth`, 4: maximum outstanding execute requests (in flight plus buffered), ≥`Latency`, power of two.
- `Opcode`, 7'b0001011: major opcode that is decoded as accepted.
- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `slv`, `xadac_if.slv`, –: decode and execute channels toward the core.
- Fields used from `xadac_pkg`:
  - `dec_req.id`, `dec_req.instr[31:0]`
  - `dec_rsp.id`, `dec_rsp.accept`
  - `exe_req.id`, `exe_req.instr`, `exe_req.rs1[31:0]`, `exe_req.rs2[31:0]`
  - `exe_rsp.id`, `exe_rsp.rd[4:0]`, `exe_rsp.data[31:0]`, `exe_rsp.we`

## Operation
- Decode: `accept`=1 iff `instr[6:0]`==`Opcode` and funct3 (`instr[14:12]`) ∈ {000 MUL, 001 MAC, 010 CLR}. All other instructions get `accept`=0. `id` is echoed.
- Decode response register holds a single entry:
  - `dec_req_ready = !dec_rsp_valid || dec_rsp_ready`.
  - A handshake loads the register, and `dec_rsp_valid` is set on the next cycle.
  - The register holds stable until `dec_rsp_ready`.
- Execute issue happens on the `exe_req` handshake. All computation is modulo 2^32, using the low 32 bits of the product.
  - MUL: data = rs1*rs2; accumulator unchanged.
  - MAC: acc ← acc + rs1*rs2; data = new acc.
  - CLR: data = old acc; acc ← 0.
- The accumulator updates at issue, so back-to-back MACs chain with no stall.
- The result (id, rd=`instr[11:7]`, data, we=1) enters a `Latency`-stage valid-tagged shift pipeline. It then enters an output FIFO sized `Depth`, and `exe_rsp` is driven from the FIFO head. Responses are always in issue order.
- Credit counter `out_cnt` (width clog2(`Depth`)+1):
  - +1 on `exe_req` handshake, −1 on `exe_rsp` handshake; unchanged when both occur in the same cycle.
  - `exe_req_ready = (out_cnt < Depth) && !rst`.
  - Because of the credit limit, the FIFO never overflows and the pipeline never stalls.
- Execute requests with an unsupported funct3 are not expected. If one arrives, it is treated as MUL.

## Timing
- Reset cycle and the first cycle after it:
  - `dec_rsp_valid`=0, `exe_rsp_valid`=0.
  - acc=0, `out_cnt`=0, pipeline and FIFO empty.
  - Response payloads are zero.
  - Readies are 0 while `rst`=1 and 1 in the first cycle after it.
- Reset mid-operation drops all in-flight and buffered results and the pending decode response. No response is produced for any of them.
- Decode latency is 1 cycle; throughput is 1/cycle when `dec_rsp_ready` is held at 1.
- Execute latency: request accepted in cycle t → `exe_rsp_valid` in cycle t+`Latency` when the FIFO is empty. Throughput is 1/cycle.
- FIFO bypass is not allowed: a result is visible on `exe_rsp` no earlier than t+`Latency`.
- With `exe_rsp_ready`=0, exactly `Depth` requests are accepted, then `exe_req_ready` drops. It rises in the cycle after the first `exe_rsp` handshake.
- The FIFO pointers wrap modulo `Depth`. Full and empty are distinguished by `out_cnt`.
- Both valid outputs are independent of their ready inputs in the same cycle (no valid←ready combinational path). `exe_req_ready` depends only on registered state.

## Configuration
- `XADAC_SLV_MAC_ACC_EN` defined: the accumulator register is present; MAC and CLR are accepted and behave as above.
- Not defined:
  - No accumulator register is built.
  - Decode accepts only funct3 000 (MUL); 001 and 010 decode with `accept`=0.
  - Execute always computes MUL.

## Test plan
- Decode: instr 0x0020_A00B (custom-0, funct3 010) then 0x0000_0033 (OP), `dec_rsp_ready`=1 → responses one cycle after each request, with accept=1 then accept=0 and ids echoed.
- MUL: rs1=0xFFFF_FFFF, rs2=2, rd=5, `Latency`=2, request in cycle 10 → `exe_rsp` in cycle 12 with data=0xFFFF_FFFE, rd=5, we=1.
- Accumulate chain with ACC_EN defined: back-to-back MAC(3,4), MAC(5,6), CLR, MUL(7,7) → data 12, 42, 42, 49 in order; acc=0 afterwards.
- Backpressure: `exe_rsp_ready`=0, `Depth`=4, continuous requests → exactly 4 accepted. Release ready for one cycle → 1 response, and `exe_req_ready` rises in the following cycle. Ids are preserved in order.
- Reset mid-flight: 3 requests outstanding, assert `rst` for 1 cycle → no responses; `exe_req_ready`=1 and acc=0 afterwards.
- Macro undefined: MAC decode → accept=0; MUL still correct.
